// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants used by the instruction encoder and the
// decoder's immediate extender.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // True when value[31:msb] are all equal, i.e. the value survives
    // truncation to msb+1 bits followed by sign extension.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] upper;
        upper = $signed(value) >>> msb;
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packing for I/S/B/J formats plus immediate range and
// alignment checking.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  immsrc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic is_shift;

    assign is_shift = (immsrc_e'(immsrc) == IMM_I) && (opcode == OP_IMM) &&
                      ((funct3 == F3_SLL) || (funct3 == F3_SR));

    always_comb begin
        instr = '0;
        err   = 1'b0;
        unique case (immsrc_e'(immsrc))
            IMM_I: begin
                if (is_shift) begin
                    // Shift forms carry funct7 in the upper bits and a 5-bit shamt.
                    instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    err   = |imm[31:5];
                end else begin
                    instr = {imm[11:0], rs1, funct3, rd, opcode};
                    err   = !fits_signed(imm, 11);
                end
            end
            IMM_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = !fits_signed(imm, 11);
            end
            IMM_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err   = !fits_signed(imm, 12) || imm[0];
            end
            IMM_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err   = !fits_signed(imm, 20) || imm[0];
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: valid/ready front end, address counter and a
// 2-entry output FIFO of {instr, addr, err}.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  immsrc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_sticky
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } fifo_entry_t;

    logic [31:0] pack_instr;
    logic        pack_err;

    fifo_entry_t mem_reg [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic [31:0] addr_reg;
    logic        err_sticky_reg;
    logic        push;
    logic        pop;

    instr_pack u_pack (
        .immsrc (immsrc),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // clr takes precedence over both handshakes, so a request or pop in a
    // clr cycle has no effect.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready && !clr;
    assign pop       = out_valid && out_ready && !clr;

    // Output comes straight from the head slot; while stalled the head slot
    // is never the write target, so the word holds.
    assign out_instr  = mem_reg[rd_ptr_reg].instr;
    assign out_addr   = mem_reg[rd_ptr_reg].addr;
    assign out_err    = mem_reg[rd_ptr_reg].err;
    assign err_sticky = err_sticky_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == gi[0])) begin
                    mem_reg[gi] <= '{instr: pack_instr, addr: addr_reg, err: pack_err};
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            count_reg      <= 2'd0;
            addr_reg       <= BASE_ADDR;
            err_sticky_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg     <= !wr_ptr_reg;
                addr_reg       <= addr_reg + 32'd4;
                err_sticky_reg <= err_sticky_reg | pack_err;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
        end
    end

endmodule
